// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types and constants for the instruction dispatcher
package video_pkg;

  // Width of each instruction word sent to the video processor
  localparam int INSTR_W = 32;

  // Default FIFO depth and post-issue idle spacing
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_GAP   = 8;

  // Dispatcher FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } disp_state_e;

  // One queued instruction: word A in the upper half, word B in the lower half
  typedef struct packed {
    logic [INSTR_W-1:0] a;
    logic [INSTR_W-1:0] b;
  } instr_pair_t;

  // Bits needed for a down-counter holding values 0..v-1; never less than 1
  function automatic int counter_width(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/instruction_fifo.sv
// rtl/instruction_fifo.sv - show-ahead synchronous FIFO with registered full and count
module instruction_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             push_ok;
  logic             pop_ok;

  // A push is judged against the registered full flag, so a push into a full
  // FIFO is dropped even when a pop frees a slot on the same edge.
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & (count_q != '0);

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^AW)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(DEPTH));
  end

  // Pointer, count and full registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate every read
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign count_o = count_q;

endmodule

// File: rtl/instruction_dispatcher.sv
// rtl/instruction_dispatcher.sv - queues host instructions and issues them to the video processor
module instruction_dispatcher
  import video_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   host_wr,
  input  logic [INSTR_W-1:0]     host_dataA,
  input  logic [INSTR_W-1:0]     host_dataB,
  output logic                   host_full,
  output logic [$clog2(DEPTH):0] host_count,
  output logic                   overflow,
  input  logic                   printtingScreen,
  output logic [INSTR_W-1:0]     dataA,
  output logic [INSTR_W-1:0]     dataB,
  output logic                   clk_en,
  output logic                   busy
);

  localparam int GW = counter_width(GAP);
  localparam int CW = $clog2(DEPTH) + 1;

  disp_state_e        state_q, state_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [INSTR_W-1:0] data_a_q, data_a_d;
  logic [INSTR_W-1:0] data_b_q, data_b_d;
  logic               clk_en_q, clk_en_d;
  logic               overflow_q, overflow_d;

  instr_pair_t        push_pair;
  instr_pair_t        head_pair;
  logic               fifo_empty;
  logic               fifo_full;
  logic [CW-1:0]      fifo_count;
  logic               fifo_pop;
  logic               can_issue;

  assign push_pair = '{a: host_dataA, b: host_dataB};

  instruction_fifo #(
    .WIDTH ($bits(instr_pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (host_wr),
    .push_data_i (push_pair),
    .pop_i       (fifo_pop),
    .head_o      (head_pair),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  // The screen-scan flag is only consulted here, at the moment of deciding to issue
  assign can_issue = ~fifo_empty & ~printtingScreen;

  // Issue FSM: pick up the head entry, pulse clk_en once, then hold off GAP cycles
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    clk_en_d = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_issue) begin
          state_d  = ST_ISSUE;
          data_a_d = head_pair.a;
          data_b_d = head_pair.b;
          clk_en_d = 1'b1;
          fifo_pop = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_GAP;
        gap_d   = GW'(GAP - 1);
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          if (can_issue) begin
            state_d  = ST_ISSUE;
            data_a_d = head_pair.a;
            data_b_d = head_pair.b;
            clk_en_d = 1'b1;
            fifo_pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Dropped pushes latch the sticky overflow flag until reset
  always_comb begin
    overflow_d = overflow_q | (host_wr & fifo_full);
  end

  // State, gap counter and registered processor-facing outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      clk_en_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      clk_en_q   <= clk_en_d;
      overflow_q <= overflow_d;
    end
  end

  assign dataA      = data_a_q;
  assign dataB      = data_b_q;
  assign clk_en     = clk_en_q;
  assign overflow   = overflow_q;
  assign host_full  = fifo_full;
  assign host_count = fifo_count;
  assign busy       = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_instruction_dispatcher.sv
// tb/tb_instruction_dispatcher.sv - self-checking bench for instruction_dispatcher
module tb_instruction_dispatcher;

  localparam int DEPTH = 16;
  localparam int GAP   = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_wr;
  logic [31:0]   host_dataA;
  logic [31:0]   host_dataB;
  logic          host_full;
  logic [CW-1:0] host_count;
  logic          overflow;
  logic          printtingScreen;
  logic [31:0]   dataA;
  logic [31:0]   dataB;
  logic          clk_en;
  logic          busy;

  always #5 clk = ~clk;

  instruction_dispatcher #(
    .DEPTH (DEPTH),
    .GAP   (GAP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .host_wr         (host_wr),
    .host_dataA      (host_dataA),
    .host_dataB      (host_dataB),
    .host_full       (host_full),
    .host_count      (host_count),
    .overflow        (overflow),
    .printtingScreen (printtingScreen),
    .dataA           (dataA),
    .dataB           (dataB),
    .clk_en          (clk_en),
    .busy            (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] sb[$];
  int          issue_cycs[$];
  int          model_count = 0;
  int          issue_count = 0;
  int          last_issue_cyc = 0;
  int          prev_issue_cyc = -100000;
  int          n_tests = 0;
  int          n_fail = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    int          exp_lat;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every clk_en pulse must match the oldest accepted push
  always @(negedge clk) begin
    if (reset === 1'b1 && clk_en === 1'b1) begin
      issue_count++;
      last_issue_cyc = cyc;
      issue_cycs.push_back(cyc);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_issue: got %0h with empty scoreboard, required no issue", {dataA, dataB});
      end else begin
        check("issue_data", {dataA, dataB}, sb.pop_front());
        model_count--;
      end
      if (prev_issue_cyc >= 0) begin
        check_int("issue_spacing_min", (cyc - prev_issue_cyc >= GAP + 1) ? 1 : 0, 1);
      end
      prev_issue_cyc = cyc;
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    host_wr    = 1'b1;
    host_dataA = a;
    host_dataB = b;
    @(posedge clk);
    if (model_count < DEPTH) begin
      sb.push_back({a, b});
      model_count++;
    end
    #1 host_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    host_wr = 1'b0;
    @(posedge clk);
    sb.delete();
    model_count    = 0;
    prev_issue_cyc = -100000;
    #1 reset = 1'b1;
  endtask

  task automatic wait_idle(input string name, output int fall_cyc);
    fall_cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        fall_cyc = cyc;
        break;
      end
    end
    if (fall_cyc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: busy still 1 after 2000 cycles, required 0", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ic0;
    int pe;
    int fall;

    vecs[0] = '{a: 32'h0000_0011, b: 32'h0000_00AB, hold: 0, exp_lat: 1};
    vecs[1] = '{a: 32'hDEAD_BEEF, b: 32'h1234_5678, hold: 0, exp_lat: 1};
    vecs[2] = '{a: 32'hA5A5_A5A5, b: 32'h5A5A_5A5A, hold: 3, exp_lat: 4};
    vecs[3] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, hold: 6, exp_lat: 7};

    reset           = 1'b0;
    host_wr         = 1'b0;
    host_dataA      = '0;
    host_dataB      = '0;
    printtingScreen = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_clk_en",   64'(clk_en),     64'd0);
    check("rst_dataA",    64'(dataA),      64'd0);
    check("rst_dataB",    64'(dataB),      64'd0);
    check("rst_busy",     64'(busy),       64'd0);
    check("rst_full",     64'(host_full),  64'd0);
    check("rst_count",    64'(host_count), 64'd0);
    check("rst_overflow", 64'(overflow),   64'd0);

    // Single issues, with and without a screen-scan hold-off
    foreach (vecs[i]) begin
      ic0 = issue_count;
      printtingScreen = (vecs[i].hold > 0);
      push(vecs[i].a, vecs[i].b);
      pe = cyc;
      repeat (vecs[i].hold) @(posedge clk);
      #1 printtingScreen = 1'b0;
      wait_idle("vec_idle", fall);
      check_int("vec_issue_count", issue_count - ic0, 1);
      check_int("vec_latency", last_issue_cyc - pe, vecs[i].exp_lat);
      check_int("vec_busy_fall", fall - last_issue_cyc, GAP + 1);
    end

    // Back-to-back entries issue exactly GAP+1 cycles apart
    ic0 = issue_count;
    issue_cycs.delete();
    push(32'h0000_0001, 32'h0000_0101);
    push(32'h0000_0002, 32'h0000_0202);
    push(32'h0000_0003, 32'h0000_0303);
    wait_idle("spacing_idle", fall);
    check_int("spacing_issue_count", issue_count - ic0, 3);
    check_int("spacing_n", issue_cycs.size(), 3);
    if (issue_cycs.size() == 3) begin
      check_int("spacing_1_2", issue_cycs[1] - issue_cycs[0], GAP + 1);
      check_int("spacing_2_3", issue_cycs[2] - issue_cycs[1], GAP + 1);
    end
    check("spacing_count", 64'(host_count), 64'd0);

    // Overflow: fill while the screen is busy, then push one more
    do_reset();
    printtingScreen = 1'b1;
    ic0 = issue_count;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(32'h1000_0000 + i, 32'h2000_0000 + i);
    end
    @(negedge clk);
    check("ovf_full",     64'(host_full),  64'd1);
    check("ovf_count",    64'(host_count), 64'(DEPTH));
    check("ovf_overflow", 64'(overflow),   64'd1);
    repeat (5) @(negedge clk);
    check_int("ovf_held_off", issue_count - ic0, 0);
    printtingScreen = 1'b0;
    wait_idle("ovf_idle", fall);
    check_int("ovf_issue_count", issue_count - ic0, DEPTH);
    check_int("ovf_sb_empty", sb.size(), 0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Reset while a GAP is in flight with 5 entries still queued
    for (int i = 0; i < 6; i++) begin
      push(32'h3000_0000 + i, 32'h4000_0000 + i);
    end
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy_pre", 64'(busy), 64'd1);
    check("mid_count_pre", 64'(host_count), 64'd5);
    reset = 1'b0;
    @(posedge clk);
    sb.delete();
    model_count    = 0;
    prev_issue_cyc = -100000;
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_clk_en",   64'(clk_en),     64'd0);
    check("mid_count",    64'(host_count), 64'd0);
    check("mid_overflow", 64'(overflow),   64'd0);
    check("mid_busy",     64'(busy),       64'd0);
    ic0 = issue_count;
    repeat (30) @(negedge clk);
    check_int("mid_no_issue", issue_count - ic0, 0);

    // Wrap-around: 40 entries pushed while issues drain the FIFO
    ic0 = issue_count;
    for (int i = 0; i < 40; i++) begin
      for (int w = 0; w < 400 && model_count >= 12; w++) @(negedge clk);
      push(32'hC000_0000 + i, ~(32'hC000_0000 + i));
    end
    wait_idle("wrap_idle", fall);
    check_int("wrap_issue_count", issue_count - ic0, 40);
    check_int("wrap_sb_empty", sb.size(), 0);
    check("wrap_count",    64'(host_count), 64'd0);
    check("wrap_overflow", 64'(overflow),   64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
